// File: rtl/ttl_ff_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ttl_ff_bank
// Description : Bank of CHANNELS edge-triggered flip-flops emulating 74LS74
//               (D) and 74LS109/112 (JK) parts inside the system clock
//               domain. The TTL clock is a sampled data signal; its edges
//               are detected against clk.
// Revision    : 1.0 - initial release
// ============================================================================
module ttl_ff_bank #(
    parameter int CHANNELS      = 1,
    parameter int MODE          = 0,
    parameter int FALLING       = 0,
    parameter int SYNC_STAGES   = 0,
    parameter int BOTH_LOW_HIGH = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] ck,
    input  logic [CHANNELS-1:0] clr_n,
    input  logic [CHANNELS-1:0] pre_n,
    input  logic [CHANNELS-1:0] d,
    input  logic [CHANNELS-1:0] k,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] q_n
);

    localparam int c_W = 5 * CHANNELS;

    // Elaboration-time parameter range checks
    generate
        if (CHANNELS < 1) begin : g_err_channels
            $error("ttl_ff_bank: CHANNELS must be at least 1");
        end
        if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_err_sync
            $error("ttl_ff_bank: SYNC_STAGES must be in 0..3");
        end
        if (MODE != 0 && MODE != 1) begin : g_err_mode
            $error("ttl_ff_bank: MODE must be 0 or 1");
        end
        if (FALLING != 0 && FALLING != 1) begin : g_err_falling
            $error("ttl_ff_bank: FALLING must be 0 or 1");
        end
    endgenerate

    logic [c_W-1:0]      w_raw;
    logic [c_W-1:0]      w_in;
    logic [CHANNELS-1:0] w_ck;
    logic [CHANNELS-1:0] w_d;
    logic [CHANNELS-1:0] w_k;
    logic [CHANNELS-1:0] w_clr_n;
    logic [CHANNELS-1:0] w_pre_n;
    logic [CHANNELS-1:0] w_edge;
    logic [CHANNELS-1:0] r_ck_p;
    logic [CHANNELS-1:0] r_q;
    logic [CHANNELS-1:0] r_qn;
    logic [CHANNELS-1:0] r_both;

    assign w_raw = {pre_n, clr_n, k, d, ck};

    // All five inputs share one delay line so they stay aligned to each other
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_in = w_raw;
        end else begin : g_sync
            logic [c_W-1:0] r_stage [SYNC_STAGES];

            // Shift chain; runs through reset so stages always hold live input
            always_ff @(posedge clk) begin
                r_stage[0] <= w_raw;
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    r_stage[s] <= r_stage[s-1];
                end
            end

            assign w_in = r_stage[SYNC_STAGES-1];
        end
    endgenerate

    assign w_ck    = w_in[CHANNELS-1:0];
    assign w_d     = w_in[2*CHANNELS-1:CHANNELS];
    assign w_k     = w_in[3*CHANNELS-1:2*CHANNELS];
    assign w_clr_n = w_in[4*CHANNELS-1:3*CHANNELS];
    assign w_pre_n = w_in[5*CHANNELS-1:4*CHANNELS];

    assign w_edge = (FALLING != 0) ? (~w_ck & r_ck_p) : (w_ck & ~r_ck_p);

    // Edge history follows ck every cycle, including reset, so release is glitch-free
    always_ff @(posedge clk) begin
        r_ck_p <= w_ck;
    end

    // Per-channel flip-flop state with clear/preset/edge priority
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (!reset_n) begin
                r_q[i]    <= 1'b0;
                r_qn[i]   <= 1'b1;
                r_both[i] <= 1'b0;
            end else begin
                r_both[i] <= ~w_clr_n[i] & ~w_pre_n[i];
                if (!w_clr_n[i] && !w_pre_n[i]) begin
                    r_q[i]  <= (BOTH_LOW_HIGH != 0);
                    r_qn[i] <= 1'b1;
                end else if (!w_clr_n[i]) begin
                    r_q[i]  <= 1'b0;
                    r_qn[i] <= 1'b1;
                end else if (!w_pre_n[i]) begin
                    r_q[i]  <= 1'b1;
                    r_qn[i] <= 1'b0;
                end else if (r_both[i]) begin
                    // Simultaneous release of both-low settles deterministically to clear
                    r_q[i]  <= 1'b0;
                    r_qn[i] <= 1'b1;
                end else if (w_edge[i]) begin
                    if (MODE == 0) begin
                        r_q[i]  <= w_d[i];
                        r_qn[i] <= ~w_d[i];
                    end else begin
                        case ({w_d[i], w_k[i]})
                            2'b01: begin
                                r_q[i]  <= 1'b0;
                                r_qn[i] <= 1'b1;
                            end
                            2'b10: begin
                                r_q[i]  <= 1'b1;
                                r_qn[i] <= 1'b0;
                            end
                            2'b11: begin
                                r_q[i]  <= ~r_q[i];
                                r_qn[i] <= ~r_qn[i];
                            end
                            default: begin
                                r_q[i]  <= r_q[i];
                                r_qn[i] <= r_qn[i];
                            end
                        endcase
                    end
                end
            end
        end
    end

    assign q   = r_q;
    assign q_n = r_qn;

endmodule
`default_nettype wire

// File: tb/tb_ttl_ff_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ttl_ff_bank
// Description : Directed and model-checked bench for ttl_ff_bank using three
//               instances: D rising (a), JK falling with clear priority (b),
//               and D with two synchroniser stages (c).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ttl_ff_bank;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] a_ck, a_clr, a_pre, a_d, a_k, a_q, a_qn;
    logic [3:0] b_ck, b_clr, b_pre, b_d, b_k, b_q, b_qn;
    logic [3:0] c_ck, c_clr, c_pre, c_d, c_k, c_q, c_qn;
    logic [3:0] ma_q, ma_qn, ma_ckp, ma_bp;
    logic [3:0] mb_q, mb_qn, mb_ckp, mb_bp;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ttl_ff_bank #(.CHANNELS(4), .MODE(0), .FALLING(0), .SYNC_STAGES(0), .BOTH_LOW_HIGH(1)) u_a (
        .clk(clk), .reset_n(rst_n), .ck(a_ck), .clr_n(a_clr), .pre_n(a_pre),
        .d(a_d), .k(a_k), .q(a_q), .q_n(a_qn));

    ttl_ff_bank #(.CHANNELS(4), .MODE(1), .FALLING(1), .SYNC_STAGES(0), .BOTH_LOW_HIGH(0)) u_b (
        .clk(clk), .reset_n(rst_n), .ck(b_ck), .clr_n(b_clr), .pre_n(b_pre),
        .d(b_d), .k(b_k), .q(b_q), .q_n(b_qn));

    ttl_ff_bank #(.CHANNELS(4), .MODE(0), .FALLING(0), .SYNC_STAGES(2), .BOTH_LOW_HIGH(1)) u_c (
        .clk(clk), .reset_n(rst_n), .ck(c_ck), .clr_n(c_clr), .pre_n(c_pre),
        .d(c_d), .k(c_k), .q(c_q), .q_n(c_qn));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour of one 4-channel bank for one clk edge
    task automatic model_step(input int mode, input int falling, input int blh, input logic rn,
                              input logic [3:0] ck, input logic [3:0] clr, input logic [3:0] pre,
                              input logic [3:0] d, input logic [3:0] k,
                              inout logic [3:0] q, inout logic [3:0] qn,
                              inout logic [3:0] ckp, inout logic [3:0] bp);
        for (int i = 0; i < 4; i++) begin
            logic e;
            e = (falling != 0) ? (~ck[i] & ckp[i]) : (ck[i] & ~ckp[i]);
            if (!rn) begin
                q[i] = 1'b0; qn[i] = 1'b1;
            end else if (!clr[i] && !pre[i]) begin
                q[i] = (blh != 0); qn[i] = 1'b1;
            end else if (!clr[i]) begin
                q[i] = 1'b0; qn[i] = 1'b1;
            end else if (!pre[i]) begin
                q[i] = 1'b1; qn[i] = 1'b0;
            end else if (bp[i]) begin
                q[i] = 1'b0; qn[i] = 1'b1;
            end else if (e) begin
                if (mode == 0) begin
                    q[i] = d[i]; qn[i] = ~d[i];
                end else if (d[i] && k[i]) begin
                    q[i] = ~q[i]; qn[i] = ~qn[i];
                end else if (d[i]) begin
                    q[i] = 1'b1; qn[i] = 1'b0;
                end else if (k[i]) begin
                    q[i] = 1'b0; qn[i] = 1'b1;
                end
            end
            bp[i]  = rn & ~clr[i] & ~pre[i];
            ckp[i] = ck[i];
        end
    endtask

    function automatic logic [3:0] rare_low();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ($urandom_range(7) == 0) ? 1'b0 : 1'b1;
        return r;
    endfunction

    task automatic test_reset();
        tick();
        tick();
        n_cmp++; if (a_q !== 4'h0)  begin n_err++; $display("FAIL reset_a_q: got %b expected 0000", a_q); end
        n_cmp++; if (a_qn !== 4'hF) begin n_err++; $display("FAIL reset_a_qn: got %b expected 1111", a_qn); end
        n_cmp++; if (b_q !== 4'h0)  begin n_err++; $display("FAIL reset_b_q: got %b expected 0000", b_q); end
        n_cmp++; if (b_qn !== 4'hF) begin n_err++; $display("FAIL reset_b_qn: got %b expected 1111", b_qn); end
        n_cmp++; if (c_q !== 4'h0)  begin n_err++; $display("FAIL reset_c_q: got %b expected 0000", c_q); end
        n_cmp++; if (c_qn !== 4'hF) begin n_err++; $display("FAIL reset_c_qn: got %b expected 1111", c_qn); end
        a_d   = 4'hF;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (a_q !== 4'h0) begin n_err++; $display("FAIL post_reset_no_edge1: got %b expected 0000", a_q); end
        tick();
        n_cmp++; if (a_q !== 4'h0) begin n_err++; $display("FAIL post_reset_no_edge2: got %b expected 0000", a_q); end
    endtask

    task automatic test_d_edges();
        a_ck = 4'h0; tick();
        n_cmp++; if (a_q !== 4'h0) begin n_err++; $display("FAIL d_fall_ignored: got %b expected 0000", a_q); end
        a_d = 4'b1011; a_ck = 4'hF; tick();
        n_cmp++; if (a_q !== 4'b1011)  begin n_err++; $display("FAIL d_rise_q: got %b expected 1011", a_q); end
        n_cmp++; if (a_qn !== 4'b0100) begin n_err++; $display("FAIL d_rise_qn: got %b expected 0100", a_qn); end
        a_d = 4'h0; a_ck = 4'h0; tick();
        n_cmp++; if (a_q !== 4'b1011) begin n_err++; $display("FAIL d_fall_hold: got %b expected 1011", a_q); end
        a_ck = 4'hF; tick();
        n_cmp++; if (a_q !== 4'h0)  begin n_err++; $display("FAIL d_rise2_q: got %b expected 0000", a_q); end
        n_cmp++; if (a_qn !== 4'hF) begin n_err++; $display("FAIL d_rise2_qn: got %b expected 1111", a_qn); end
        a_ck = 4'h0; tick();
        a_d = 4'hF; a_ck = 4'b0001; tick();
        n_cmp++; if (a_q !== 4'b0001) begin n_err++; $display("FAIL d_single_chan: got %b expected 0001", a_q); end
        tick();
        n_cmp++; if (a_q !== 4'b0001) begin n_err++; $display("FAIL d_static_ck: got %b expected 0001", a_q); end
    endtask

    task automatic test_jk_falling();
        logic [1:0] jk [5];
        logic       eq [5];
        logic [3:0] prev, exp;
        jk = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
        eq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        prev = 4'h0;
        for (int s = 0; s < 5; s++) begin
            b_ck = 4'hF; tick();
            n_cmp++; if (b_q !== prev) begin n_err++; $display("FAIL jk_rise_ignored[%0d]: got %b expected %b", s, b_q, prev); end
            b_d = {2'b00, 1'b1, jk[s][1]};
            b_k = {3'b000, jk[s][0]};
            b_ck = 4'h0; tick();
            exp = {2'b00, 1'b1, eq[s]};
            n_cmp++; if (b_q !== exp)   begin n_err++; $display("FAIL jk_q[%0d]: got %b expected %b", s, b_q, exp); end
            n_cmp++; if (b_qn !== ~exp) begin n_err++; $display("FAIL jk_qn[%0d]: got %b expected %b", s, b_qn, ~exp); end
            prev = exp;
        end
        b_d = 4'h0; b_k = 4'h0;
    endtask

    task automatic test_both_low();
        a_clr = 4'h0; a_pre = 4'h0; tick();
        n_cmp++; if (a_q !== 4'hF || a_qn !== 4'hF) begin n_err++; $display("FAIL both_low_blh1: got q=%b qn=%b expected 1111/1111", a_q, a_qn); end
        tick();
        a_clr = 4'hF; a_pre = 4'hF; tick();
        n_cmp++; if (a_q !== 4'h0 || a_qn !== 4'hF) begin n_err++; $display("FAIL both_release: got q=%b qn=%b expected 0000/1111", a_q, a_qn); end
        tick();
        n_cmp++; if (a_q !== 4'h0 || a_qn !== 4'hF) begin n_err++; $display("FAIL both_release_hold: got q=%b qn=%b expected 0000/1111", a_q, a_qn); end
        a_clr = 4'h0; a_pre = 4'h0; tick();
        a_clr = 4'hF; tick();
        n_cmp++; if (a_q !== 4'hF || a_qn !== 4'h0) begin n_err++; $display("FAIL clr_only_release: got q=%b qn=%b expected 1111/0000", a_q, a_qn); end
        a_pre = 4'hF; tick();
        n_cmp++; if (a_q !== 4'hF || a_qn !== 4'h0) begin n_err++; $display("FAIL preset_release_hold: got q=%b qn=%b expected 1111/0000", a_q, a_qn); end
        a_clr = 4'h0; a_pre = 4'h0; tick();
        a_pre = 4'hF; tick();
        n_cmp++; if (a_q !== 4'h0 || a_qn !== 4'hF) begin n_err++; $display("FAIL pre_only_release: got q=%b qn=%b expected 0000/1111", a_q, a_qn); end
        a_clr = 4'hF; tick();
        b_clr = 4'h0; b_pre = 4'h0; tick();
        n_cmp++; if (b_q !== 4'h0 || b_qn !== 4'hF) begin n_err++; $display("FAIL both_low_blh0: got q=%b qn=%b expected 0000/1111", b_q, b_qn); end
        b_clr = 4'hF; b_pre = 4'hF; tick();
        n_cmp++; if (b_q !== 4'h0 || b_qn !== 4'hF) begin n_err++; $display("FAIL blh0_release: got q=%b qn=%b expected 0000/1111", b_q, b_qn); end
        b_clr = 4'b1100; b_pre = 4'b1010; tick();
        n_cmp++; if (b_q !== 4'b0100 || b_qn !== 4'b1011) begin n_err++; $display("FAIL mixed_chan: got q=%b qn=%b expected 0100/1011", b_q, b_qn); end
        b_clr = 4'hF; b_pre = 4'hF; tick();
    endtask

    task automatic test_preset_discard();
        a_ck = 4'h0; a_d = 4'h0; tick();
        a_pre = 4'h0; a_ck = 4'hF; tick();
        n_cmp++; if (a_q !== 4'hF || a_qn !== 4'h0) begin n_err++; $display("FAIL pre_vs_edge: got q=%b qn=%b expected 1111/0000", a_q, a_qn); end
        a_pre = 4'hF; tick();
        n_cmp++; if (a_q !== 4'hF) begin n_err++; $display("FAIL pre_edge_discarded: got %b expected 1111", a_q); end
        tick();
        a_ck = 4'h0; tick();
        a_ck = 4'hF; tick();
        n_cmp++; if (a_q !== 4'h0 || a_qn !== 4'hF) begin n_err++; $display("FAIL next_edge_after_pre: got q=%b qn=%b expected 0000/1111", a_q, a_qn); end
        a_ck = 4'h0; tick();
        a_d = 4'hF; a_clr = 4'h0; a_ck = 4'hF; tick();
        n_cmp++; if (a_q !== 4'h0) begin n_err++; $display("FAIL clr_vs_edge: got %b expected 0000", a_q); end
        a_clr = 4'hF; tick();
        n_cmp++; if (a_q !== 4'h0) begin n_err++; $display("FAIL clr_edge_discarded: got %b expected 0000", a_q); end
    endtask

    task automatic test_sync2();
        c_d = 4'hF; c_ck = 4'hF; tick();
        n_cmp++; if (c_q !== 4'h0) begin n_err++; $display("FAIL sync_lat1: got %b expected 0000", c_q); end
        c_d = 4'h0; tick();
        n_cmp++; if (c_q !== 4'h0) begin n_err++; $display("FAIL sync_lat2: got %b expected 0000", c_q); end
        tick();
        n_cmp++; if (c_q !== 4'hF || c_qn !== 4'h0) begin n_err++; $display("FAIL sync_lat3: got q=%b qn=%b expected 1111/0000", c_q, c_qn); end
        c_clr = 4'h0; tick();
        n_cmp++; if (c_q !== 4'hF) begin n_err++; $display("FAIL sync_clr1: got %b expected 1111", c_q); end
        c_clr = 4'hF; tick();
        n_cmp++; if (c_q !== 4'hF) begin n_err++; $display("FAIL sync_clr2: got %b expected 1111", c_q); end
        tick();
        n_cmp++; if (c_q !== 4'h0 || c_qn !== 4'hF) begin n_err++; $display("FAIL sync_clr3: got q=%b qn=%b expected 0000/1111", c_q, c_qn); end
    endtask

    task automatic test_random();
        logic [3:0] m;
        rst_n = 1'b0;
        a_ck = 4'($urandom); b_ck = 4'($urandom);
        model_step(0, 0, 1, rst_n, a_ck, a_clr, a_pre, a_d, a_k, ma_q, ma_qn, ma_ckp, ma_bp);
        model_step(1, 1, 0, rst_n, b_ck, b_clr, b_pre, b_d, b_k, mb_q, mb_qn, mb_ckp, mb_bp);
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            a_ck = 4'($urandom); a_d = 4'($urandom); a_k = 4'($urandom);
            a_clr = rare_low(); a_pre = rare_low();
            b_ck = 4'($urandom); b_d = 4'($urandom); b_k = 4'($urandom);
            b_clr = rare_low(); b_pre = rare_low();
            model_step(0, 0, 1, rst_n, a_ck, a_clr, a_pre, a_d, a_k, ma_q, ma_qn, ma_ckp, ma_bp);
            model_step(1, 1, 0, rst_n, b_ck, b_clr, b_pre, b_d, b_k, mb_q, mb_qn, mb_ckp, mb_bp);
            tick();
            n_cmp++; if (a_q !== ma_q || a_qn !== ma_qn) begin n_err++; $display("FAIL rand_a[%0d]: got q=%b qn=%b expected %b/%b", n, a_q, a_qn, ma_q, ma_qn); end
            n_cmp++; if (b_q !== mb_q || b_qn !== mb_qn) begin n_err++; $display("FAIL rand_b[%0d]: got q=%b qn=%b expected %b/%b", n, b_q, b_qn, mb_q, mb_qn); end
            m = ~(ma_q & ma_qn);
            n_cmp++; if ((a_qn & m) !== (~a_q & m)) begin n_err++; $display("FAIL inv_a[%0d]: got q=%b qn=%b expected qn=~q on %b", n, a_q, a_qn, m); end
            n_cmp++; if (b_qn !== ~b_q) begin n_err++; $display("FAIL inv_b[%0d]: got q=%b qn=%b expected qn=~q", n, b_q, b_qn); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_ck = 4'hF; a_clr = 4'hF; a_pre = 4'hF; a_d = 4'h0; a_k = 4'h0;
        b_ck = 4'h0; b_clr = 4'hF; b_pre = 4'hF; b_d = 4'h0; b_k = 4'h0;
        c_ck = 4'h0; c_clr = 4'hF; c_pre = 4'hF; c_d = 4'h0; c_k = 4'h0;
        ma_q = 4'h0; ma_qn = 4'hF; ma_ckp = 4'h0; ma_bp = 4'h0;
        mb_q = 4'h0; mb_qn = 4'hF; mb_ckp = 4'h0; mb_bp = 4'h0;
        test_reset();
        test_d_edges();
        test_jk_falling();
        test_both_low();
        test_preset_discard();
        test_sync2();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000ns");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
